dr32e_data_mem: RTL and testbench



---
 rtl/dr32e_pkg.sv | 28 ++
 rtl/dr32e_mem_resp_pipe.sv | 38 +++
 rtl/dr32e_data_mem.sv | 158 +++++++++++++++
 tb/tb_dr32e_data_mem.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dr32e_pkg.sv
// Shared types and helpers for the dr32e data-side memory responder.
package dr32e_pkg;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] data;
    } dr32e_mem_resp_t;

    typedef enum logic {
        GNT_IDLE = 1'b0,
        GNT_WAIT = 1'b1
    } dr32e_gnt_state_e;

    // Hamming(39,32) check bits; each bit is the parity of the data bits selected by its mask.
    function automatic logic [6:0] secded39_enc(input logic [31:0] data);
        logic [6:0] chk;
        chk[0] = ^(data & 32'h2606_BD25);
        chk[1] = ^(data & 32'hDEBA_8050);
        chk[2] = ^(data & 32'h413D_89AA);
        chk[3] = ^(data & 32'h3123_4ED1);
        chk[4] = ^(data & 32'hC2C1_323B);
        chk[5] = ^(data & 32'h2DCC_624C);
        chk[6] = ^(data & 32'h9850_5586);
        return chk;
    endfunction

endpackage

// File: rtl/dr32e_mem_resp_pipe.sv
// Fixed-depth response shift register; grant loads stage 0, the last stage feeds the bus outputs.
module dr32e_mem_resp_pipe
    import dr32e_pkg::*;
#(
    parameter int unsigned Depth = 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  dr32e_mem_resp_t resp_i,
    output dr32e_mem_resp_t resp_o
);

    dr32e_mem_resp_t stage_q [Depth];
    dr32e_mem_resp_t stage_d [Depth];

    always_comb begin
        stage_d[0] = resp_i;
        for (int k = 1; k < Depth; k++) begin
            stage_d[k] = stage_q[k-1];
        end
    end

    // Reset clears data as well as valid so the outputs read zero while idle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < Depth; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < Depth; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    assign resp_o = stage_q[Depth-1];

endmodule

// File: rtl/dr32e_data_mem.sv
// Data-side memory responder: grant FSM, byte-writable word array and in-order response pipeline.
//   state    | meaning
//   GNT_IDLE | no request pending; grants at once when GntWait is 0
//   GNT_WAIT | request held, counting wcnt up to GntWait before granting
module dr32e_data_mem
    import dr32e_pkg::*;
#(
    parameter bit          MemECC       = 1'b0,
    parameter int unsigned MemDataWidth = MemECC ? 32 + 7 : 32,
    parameter int unsigned MemWords     = 1024,
    parameter logic [31:0] BaseAddr     = 32'h0000_0000,
    parameter int unsigned RespLatency  = 1,
    parameter int unsigned GntWait      = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    data_req_i,
    input  logic [31:0]             data_addr_i,
    input  logic                    data_we_i,
    input  logic [3:0]              data_be_i,
    input  logic [MemDataWidth-1:0] data_wdata_i,
    output logic                    data_gnt_o,
    output logic                    data_rvalid_o,
    output logic                    data_err_o,
    output logic [MemDataWidth-1:0] data_rdata_o
);

    localparam int unsigned AddrW    = $clog2(MemWords);
    localparam logic [32:0] MemBytes = 33'(MemWords) << 2;
    localparam logic [2:0]  GntWaitW = 3'(GntWait);

    if (MemWords < 4 || (MemWords & (MemWords - 1)) != 0) begin : g_chk_words
        $error("dr32e_data_mem: MemWords must be a power of two >= 4");
    end
    if (RespLatency < 1 || RespLatency > 8) begin : g_chk_lat
        $error("dr32e_data_mem: RespLatency must be in 1..8");
    end
    if (GntWait > 7) begin : g_chk_wait
        $error("dr32e_data_mem: GntWait must be in 0..7");
    end
    if (MemDataWidth != (MemECC ? 39 : 32)) begin : g_chk_width
        $error("dr32e_data_mem: MemDataWidth must be 39 with ECC, 32 without");
    end
    if ((64'(BaseAddr) % 64'(MemBytes)) != 64'd0) begin : g_chk_align
        $error("dr32e_data_mem: BaseAddr must be aligned to the memory size");
    end
    if ((64'(BaseAddr) + 64'(MemBytes)) > 64'h1_0000_0000) begin : g_chk_wrap
        $error("dr32e_data_mem: memory window wraps past 2^32");
    end

    dr32e_gnt_state_e state_q, state_d;
    logic [2:0]       wcnt_q, wcnt_d;
    logic             gnt;

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        gnt     = 1'b0;
        case (state_q)
            GNT_IDLE: begin
                if (data_req_i) begin
                    if (GntWait == 0) begin
                        gnt = 1'b1;
                    end else begin
                        state_d = GNT_WAIT;
                        wcnt_d  = 3'd1;
                    end
                end
            end
            GNT_WAIT: begin
                if (!data_req_i) begin
                    state_d = GNT_IDLE;
                    wcnt_d  = 3'd0;
                end else if (wcnt_q == GntWaitW) begin
                    gnt     = 1'b1;
                    state_d = GNT_IDLE;
                    wcnt_d  = 3'd0;
                end else begin
                    wcnt_d = wcnt_q + 3'd1;
                end
            end
            default: begin
                state_d = GNT_IDLE;
                wcnt_d  = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= GNT_IDLE;
            wcnt_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    assign data_gnt_o = gnt;

    logic [31:0]      addr_off;
    logic             in_range;
    logic [AddrW-1:0] word_idx;
    logic [31:0]      rd_word;

    assign addr_off = data_addr_i - BaseAddr;
    assign in_range = (data_addr_i >= BaseAddr) && ({1'b0, addr_off} < MemBytes);
    assign word_idx = addr_off[AddrW+1:2];

    // Contents survive reset, so the array has no reset branch.
    logic [31:0] mem [MemWords];

    always_ff @(posedge clk_i) begin
        if (gnt && data_we_i && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (data_be_i[b]) begin
                    mem[word_idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rd_word = mem[word_idx];

    dr32e_mem_resp_t resp_in, resp_out;

    always_comb begin
        resp_in       = '0;
        resp_in.valid = gnt;
        resp_in.err   = gnt & ~in_range;
        if (gnt && in_range && !data_we_i) begin
            resp_in.data = rd_word;
        end
    end

    dr32e_mem_resp_pipe #(
        .Depth (RespLatency)
    ) u_resp_pipe (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .resp_i (resp_in),
        .resp_o (resp_out)
    );

    assign data_rvalid_o = resp_out.valid;
    assign data_err_o    = resp_out.err;

    // Error and idle stages carry zero data, and the encoding of zero is zero.
    if (MemECC) begin : g_ecc
        assign data_rdata_o = {secded39_enc(resp_out.data), resp_out.data};
    end else begin : g_no_ecc
        assign data_rdata_o = resp_out.data;
    end

    logic unused_bits;
    assign unused_bits = ^{addr_off, data_wdata_i};

endmodule

// File: tb/tb_dr32e_data_mem.sv
// Directed bench for dr32e_data_mem: three configurations checked against a transaction-level model.
module tb_dr32e_data_mem;

    typedef struct {
        longint      due;
        logic        err;
        logic [38:0] data;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        req   [3];
    logic        we    [3];
    logic [31:0] addr  [3];
    logic [3:0]  be    [3];
    logic [31:0] wd    [3];
    wire  [2:0]  gnt_v;
    wire  [2:0]  rv_v;
    wire  [2:0]  er_v;
    wire  [31:0] rd0;
    wire  [31:0] rd1;
    wire  [38:0] rd2;

    int unsigned lat_p   [3] = '{1, 3, 3};
    int unsigned gw_p    [3] = '{0, 2, 0};
    int unsigned words_p [3] = '{1024, 16, 64};
    logic [31:0] base_p  [3] = '{32'h0, 32'h1000, 32'h0};
    bit          ecc_p   [3] = '{1'b0, 1'b0, 1'b1};

    longint      cyc;
    int          n_chk;
    int          n_fail;
    exp_t        exp_q [3][$];
    logic [31:0] mem_m [longint];
    logic [38:0] last_rd  [3];
    logic        last_err [3];

    dr32e_data_mem u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .data_req_i(req[0]), .data_addr_i(addr[0]),
        .data_we_i(we[0]), .data_be_i(be[0]), .data_wdata_i(wd[0]),
        .data_gnt_o(gnt_v[0]), .data_rvalid_o(rv_v[0]), .data_err_o(er_v[0]), .data_rdata_o(rd0)
    );

    dr32e_data_mem #(
        .MemWords(16), .BaseAddr(32'h1000), .RespLatency(3), .GntWait(2)
    ) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .data_req_i(req[1]), .data_addr_i(addr[1]),
        .data_we_i(we[1]), .data_be_i(be[1]), .data_wdata_i(wd[1]),
        .data_gnt_o(gnt_v[1]), .data_rvalid_o(rv_v[1]), .data_err_o(er_v[1]), .data_rdata_o(rd1)
    );

    dr32e_data_mem #(
        .MemECC(1'b1), .MemWords(64), .RespLatency(3)
    ) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n), .data_req_i(req[2]), .data_addr_i(addr[2]),
        .data_we_i(we[2]), .data_be_i(be[2]), .data_wdata_i({7'd0, wd[2]}),
        .data_gnt_o(gnt_v[2]), .data_rvalid_o(rv_v[2]), .data_err_o(er_v[2]), .data_rdata_o(rd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [38:0] get_rd(input int i);
        case (i)
            0:       return {7'd0, rd0};
            1:       return {7'd0, rd1};
            default: return rd2;
        endcase
    endfunction

    function automatic logic [31:0] enc_mask(input int k);
        case (k)
            0:       return 32'h2606_BD25;
            1:       return 32'hDEBA_8050;
            2:       return 32'h413D_89AA;
            3:       return 32'h3123_4ED1;
            4:       return 32'hC2C1_323B;
            5:       return 32'h2DCC_624C;
            default: return 32'h9850_5586;
        endcase
    endfunction

    function automatic logic [6:0] tb_enc(input logic [31:0] d);
        logic [6:0] c;
        for (int k = 0; k < 7; k++) c[k] = ^(d & enc_mask(k));
        return c;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a granted access resolves at once against the model memory; its response is due lat cycles later.
    task automatic push_model(input int i, input bit w, input logic [31:0] a,
                              input logic [3:0] b, input logic [31:0] d);
        exp_t        e;
        longint      off;
        longint      key;
        logic [31:0] cur;
        bit          inr;
        off   = longint'(a) - longint'(base_p[i]);
        inr   = (off >= 0) && (off < 4 * longint'(words_p[i]));
        e.due = cyc + longint'(lat_p[i]);
        e.err = !inr;
        e.data = '0;
        if (inr) begin
            key = (longint'(i) << 32) + (off >> 2);
            cur = mem_m.exists(key) ? mem_m[key] : 32'h0;
            if (w) begin
                for (int k = 0; k < 4; k++) if (b[k]) cur[8*k +: 8] = d[8*k +: 8];
                mem_m[key] = cur;
            end else begin
                e.data = ecc_p[i] ? {tb_enc(cur), cur} : {7'd0, cur};
            end
        end
        exp_q[i].push_back(e);
    endtask

    // Raise (or keep) req with new fields, wait for gnt, check its delay; returns just after the consuming edge.
    task automatic access(input int i, input bit w, input logic [31:0] a,
                          input logic [3:0] b, input logic [31:0] d);
        int waited = 0;
        bit got    = 1'b0;
        req[i] = 1'b1; we[i] = w; addr[i] = a; be[i] = b; wd[i] = d;
        while (!got && waited < 20) begin
            @(negedge clk);
            if (gnt_v[i]) got = 1'b1;
            else waited++;
        end
        if (!got) begin
            check($sformatf("gnt_timeout[%0d]", i), 64'(got), 64'd1);
        end else begin
            check($sformatf("gnt_delay[%0d]", i), 64'(waited), 64'(gw_p[i]));
            push_model(i, w, a, b, d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int i);
        req[i] = 1'b0;
        we[i]  = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_gnt[%0d]", tag, i), 64'(gnt_v[i]), 64'd0);
            check($sformatf("%s_rvalid[%0d]", tag, i), 64'(rv_v[i]), 64'd0);
            check($sformatf("%s_err[%0d]", tag, i), 64'(er_v[i]), 64'd0);
            check($sformatf("%s_rdata[%0d]", tag, i), 64'(get_rd(i)), 64'd0);
        end
    endtask

    // Per-cycle compare: rvalid must be high exactly when a response is due, with the modelled err/rdata.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 3; i++) begin
                bit   due_now;
                exp_t e;
                due_now = (exp_q[i].size() > 0) && (exp_q[i][0].due == cyc);
                check($sformatf("rvalid[%0d]", i), 64'(rv_v[i]), 64'(due_now));
                if (due_now) begin
                    e = exp_q[i].pop_front();
                    check($sformatf("err[%0d]", i), 64'(er_v[i]), 64'(e.err));
                    check($sformatf("rdata[%0d]", i), 64'(get_rd(i)), 64'(e.data));
                end
                if (rv_v[i]) begin
                    last_rd[i]  = get_rd(i);
                    last_err[i] = er_v[i];
                end
            end
        end
    end

    initial begin
        cyc    = 0;
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; be[i] = '0; wd[i] = '0;
            last_rd[i] = '0; last_err[i] = 1'b0;
        end
        #2;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_cyc(1);

        // Full write then back-to-back read sees the new word
        access(0, 1'b1, 32'h10, 4'b1111, 32'hDEADBEEF);
        access(0, 1'b0, 32'h10, 4'b1111, 32'h0);
        idle(0);
        wait_cyc(3);
        check("lit_full_write", 64'(last_rd[0]), 64'h0000_0000_DEAD_BEEF);

        access(0, 1'b1, 32'h10, 4'b0010, 32'h0000AB00);
        access(0, 1'b0, 32'h10, 4'b0000, 32'h0);
        idle(0);
        wait_cyc(3);
        check("lit_partial_write", 64'(last_rd[0]), 64'h0000_0000_DEAD_ABEF);

        access(0, 1'b0, 32'h0000_1000, 4'b1111, 32'h0);
        idle(0);
        wait_cyc(3);
        check("lit_oor_err0", 64'(last_err[0]), 64'd1);
        check("lit_oor_rdata0", 64'(last_rd[0]), 64'd0);
        access(0, 1'b0, 32'hFFFF_FFFC, 4'b1111, 32'h0);
        idle(0);

        // GntWait=2, RespLatency=3: preload then four held reads
        for (int k = 0; k < 4; k++) begin
            access(1, 1'b1, 32'h1000 + 32'(4 * k), 4'b1111, 32'hA0A0_0000 + 32'(k));
            idle(1);
            wait_cyc(1);
        end
        for (int k = 0; k < 4; k++) access(1, 1'b0, 32'h1000 + 32'(4 * k), 4'b1111, 32'h0);
        idle(1);
        wait_cyc(6);
        check("lit_wait_read3", 64'(last_rd[1]), 64'h0000_0000_A0A0_0003);

        // Window edges: one past the top, just below the base, and the last word
        access(1, 1'b0, 32'h1040, 4'b1111, 32'h0);
        idle(1);
        wait_cyc(6);
        check("lit_oor_err1", 64'(last_err[1]), 64'd1);
        check("lit_oor_rdata1", 64'(last_rd[1]), 64'd0);
        access(1, 1'b1, 32'h1040, 4'b1111, 32'hBAD0_BAD0);
        access(1, 1'b0, 32'h0FFC, 4'b1111, 32'h0);
        access(1, 1'b0, 32'h1000, 4'b1111, 32'h0);
        idle(1);
        wait_cyc(6);
        check("lit_word0_kept", 64'(last_rd[1]), 64'h0000_0000_A0A0_0000);
        access(1, 1'b1, 32'h103C, 4'b1111, 32'h5555_AAAA);
        access(1, 1'b0, 32'h103C, 4'b1111, 32'h0);
        idle(1);
        wait_cyc(6);
        check("lit_top_word", 64'(last_rd[1]), 64'h0000_0000_5555_AAAA);

        // ECC build
        access(2, 1'b1, 32'h0, 4'b1111, 32'h0000_0001);
        access(2, 1'b0, 32'h0, 4'b1111, 32'h0);
        idle(2);
        wait_cyc(5);
        check("lit_ecc_one", 64'(last_rd[2]), 64'h0000_0019_0000_0001);
        access(2, 1'b1, 32'h10, 4'b1111, 32'h1234_5678);
        access(2, 1'b0, 32'h10, 4'b1111, 32'h0);
        access(2, 1'b0, 32'h100, 4'b1111, 32'h0);
        idle(2);
        wait_cyc(5);
        check("lit_ecc_oor", 64'(last_rd[2]), 64'd0);

        // Reset with two reads in flight
        access(2, 1'b0, 32'h0, 4'b1111, 32'h0);
        access(2, 1'b0, 32'h10, 4'b1111, 32'h0);
        idle(2);
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        for (int i = 0; i < 3; i++) exp_q[i].delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_cyc(6);
        access(2, 1'b0, 32'h10, 4'b1111, 32'h0);
        idle(2);
        access(0, 1'b0, 32'h10, 4'b1111, 32'h0);
        idle(0);
        wait_cyc(6);
        check("lit_after_rst2", 64'(last_rd[2]), {25'd0, tb_enc(32'h1234_5678), 32'h1234_5678});
        check("lit_after_rst0", 64'(last_rd[0]), 64'h0000_0000_DEAD_ABEF);

        for (int i = 0; i < 3; i++) check($sformatf("drained[%0d]", i), 64'(exp_q[i].size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
